// File: rtl/mul_issue_unit_pkg.sv
// Shared types for the multiplier issue path: data word, multiply op
// encoding and the nominal multiplier latency.
package mgt_01_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] data_u;

  typedef enum logic [1:0] {
    MUL_U    = 2'd0,
    MULH_U   = 2'd1,
    MULHSU_U = 2'd2,
    MULHU_U  = 2'd3
  } mul_ops_e;

  localparam int MUL_LATENCY_C = 3;

endpackage

// File: rtl/mul_issue_unit_if.sv
// Issue and writeback handshakes between the pipeline and the
// multiplier issue unit.
interface mul_issue_unit_if #(
  parameter int TAG_W = 5
) ();
  import mgt_01_pkg::*;

  logic             issue_valid;
  logic             issue_ready;
  mul_ops_e         issue_op;
  data_u            issue_rs1;
  data_u            issue_rs2;
  logic [TAG_W-1:0] issue_rd;

  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_rd;
  data_u            wb_data;

  modport master (
    output issue_valid, issue_op,
    output issue_rs1, issue_rs2, issue_rd,
    input  issue_ready,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready
  );

  modport slave (
    input  issue_valid, issue_op,
    input  issue_rs1, issue_rs2, issue_rd,
    output issue_ready,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready
  );

endinterface

// File: rtl/mul_issue_unit_track_stage.sv
// One {valid, rd} slot of the destination-tag tracker; flush kills the
// slot even while the pipeline is frozen.
module mul_track_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             d_valid,
  input  logic [TAG_W-1:0] d_rd,
  output logic             q_valid,
  output logic [TAG_W-1:0] q_rd
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_rd    <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
    end else if (en) begin
      q_valid <= d_valid;
      q_rd    <= d_rd;
    end
  end

endmodule

// File: rtl/mul_issue_unit.sv
// Issue/tracking front-end for the fixed-latency pipelined multiplier:
// operand drive, rd tag tracking, hazard query and writeback.
module mul_issue_unit
  import mgt_01_pkg::*;
#(
  parameter int  MUL_LATENCY = MUL_LATENCY_C,
  parameter int  TAG_W       = 5,
  localparam int CNT_W       = $clog2(MUL_LATENCY + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,

  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  mul_ops_e         issue_op_i,
  input  data_u            issue_rs1_i,
  input  data_u            issue_rs2_i,
  input  logic [TAG_W-1:0] issue_rd_i,

  input  logic             flush_i,

  output data_u            mul_op_A_o,
  output data_u            mul_op_B_o,
  output mul_ops_e         mul_ops_o,
  output logic             mul_clk_en_o,
  input  data_u            mul_result_i,

  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [TAG_W-1:0] wb_rd_o,
  output data_u            wb_data_o,

  input  logic [TAG_W-1:0] q_rs1_i,
  input  logic [TAG_W-1:0] q_rs2_i,
  output logic             hazard_o,
  output logic [CNT_W-1:0] inflight_o
);

  localparam int HEAD = MUL_LATENCY - 1;

  logic             stall;
  logic             accept;
  logic             wb_fire;

  logic             stg_valid [MUL_LATENCY];
  logic [TAG_W-1:0] stg_rd    [MUL_LATENCY];

  logic [CNT_W-1:0] cnt;

  assign stall         = wb_valid_o && !wb_ready_i;
  assign mul_clk_en_o  = !stall;
  assign issue_ready_o = !stall && !flush_i;
  assign accept        = issue_valid_i && issue_ready_o;
  assign wb_fire       = wb_valid_o && wb_ready_i;

  // Idle operands are zeroed to keep the multiplier array quiet.
  assign mul_op_A_o = accept ? issue_rs1_i : '0;
  assign mul_op_B_o = accept ? issue_rs2_i : '0;
  assign mul_ops_o  = accept ? issue_op_i  : MUL_U;

  for (genvar i = 0; i < MUL_LATENCY; i++) begin : g_trk
    logic             d_valid;
    logic [TAG_W-1:0] d_rd;

    if (i == 0) begin : g_in
      assign d_valid = accept;
      assign d_rd    = accept ? issue_rd_i : '0;
    end else begin : g_sh
      assign d_valid = stg_valid[i-1];
      assign d_rd    = stg_rd[i-1];
    end

    mul_track_stage #(
      .TAG_W (TAG_W)
    ) u_stage (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .en      (mul_clk_en_o),
      .flush   (flush_i),
      .d_valid (d_valid),
      .d_rd    (d_rd),
      .q_valid (stg_valid[i]),
      .q_rd    (stg_rd[i])
    );
  end

  assign wb_valid_o = stg_valid[HEAD];
  assign wb_rd_o    = stg_rd[HEAD];
  assign wb_data_o  = wb_valid_o ? mul_result_i : '0;

  // x0 is never a real dependency, so rd == 0 never raises a hazard.
  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      if (stg_valid[i] && (stg_rd[i] != '0) &&
          ((stg_rd[i] == q_rs1_i) ||
           (stg_rd[i] == q_rs2_i)))
        hazard_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        accept && !wb_fire: cnt <= cnt + CNT_W'(1);
        !accept && wb_fire: cnt <= cnt - CNT_W'(1);
        default:            cnt <= cnt;
      endcase
    end
  end

  assign inflight_o = cnt;

endmodule

// File: tb/tb_mul_issue_unit.sv
// Directed bench for mul_issue_unit with a behavioural 3-stage
// multiplier gated by mul_clk_en.
module tb_mul_issue_unit;
  import mgt_01_pkg::*;

  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [TAG_W-1:0] q_rs1;
  logic [TAG_W-1:0] q_rs2;
  logic hazard;
  logic [1:0] inflight;
  data_u mul_a;
  data_u mul_b;
  mul_ops_e mul_op;
  logic mul_en;
  data_u mul_res;

  int n_chk  = 0;
  int n_fail = 0;

  mul_issue_unit_if #(.TAG_W(TAG_W)) bus ();

  always #5 clk = ~clk;

  mul_issue_unit #(
    .MUL_LATENCY (3),
    .TAG_W       (TAG_W)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .issue_valid_i (bus.issue_valid),
    .issue_ready_o (bus.issue_ready),
    .issue_op_i    (bus.issue_op),
    .issue_rs1_i   (bus.issue_rs1),
    .issue_rs2_i   (bus.issue_rs2),
    .issue_rd_i    (bus.issue_rd),
    .flush_i       (flush),
    .mul_op_A_o    (mul_a),
    .mul_op_B_o    (mul_b),
    .mul_ops_o     (mul_op),
    .mul_clk_en_o  (mul_en),
    .mul_result_i  (mul_res),
    .wb_valid_o    (bus.wb_valid),
    .wb_ready_i    (bus.wb_ready),
    .wb_rd_o       (bus.wb_rd),
    .wb_data_o     (bus.wb_data),
    .q_rs1_i       (q_rs1),
    .q_rs2_i       (q_rs2),
    .hazard_o      (hazard),
    .inflight_o    (inflight)
  );

  function automatic data_u mul_ref(mul_ops_e op, data_u a, data_u b);
    logic signed [65:0] x, y, p;
    x = (op == MULH_U || op == MULHSU_U) ? {{34{a[31]}}, a} : {34'b0, a};
    y = (op == MULH_U) ? {{34{b[31]}}, b} : {34'b0, b};
    p = x * y;
    return (op == MUL_U) ? p[31:0] : p[63:32];
  endfunction

  data_u pipe [3] = '{default: '0};
  always @(posedge clk) begin
    if (mul_en) begin
      pipe[0] <= mul_ref(mul_op, mul_a, mul_b);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end
  assign mul_res = pipe[2];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(mul_ops_e op, data_u a, data_u b, logic [TAG_W-1:0] rd);
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_rs1   = a;
    bus.issue_rs2   = b;
    bus.issue_rd    = rd;
  endtask

  task automatic idle;
    bus.issue_valid = 1'b0;
    bus.issue_op    = MUL_U;
    bus.issue_rs1   = '0;
    bus.issue_rs2   = '0;
    bus.issue_rd    = '0;
  endtask

  task automatic check_wb(string tag, data_u d, logic [TAG_W-1:0] rd);
    check({tag, "_v"}, 64'(bus.wb_valid), 64'(1));
    check({tag, "_d"}, 64'(bus.wb_data), 64'(d));
    check({tag, "_rd"}, 64'(bus.wb_rd), 64'(rd));
  endtask

  mul_ops_e s_op [4] = '{MUL_U, MULH_U, MUL_U, MULHU_U};
  data_u    s_a  [4] = '{32'd45, 32'd91234, 32'd91234, 32'hFFFF_FFF7};
  data_u    s_b  [4] = '{32'd1, 32'd102345, 32'd102345, 32'hFFFF_FFF6};

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    q_rs1 = '0;
    q_rs2 = '0;
    bus.wb_ready = 1'b1;
    idle();
    #1;
    check("rst_wb_valid", 64'(bus.wb_valid), 64'(0));
    check("rst_wb_rd", 64'(bus.wb_rd), 64'(0));
    check("rst_wb_data", 64'(bus.wb_data), 64'(0));
    check("rst_hazard", 64'(hazard), 64'(0));
    check("rst_ready", 64'(bus.issue_ready), 64'(1));
    check("rst_clk_en", 64'(mul_en), 64'(1));
    check("rst_inflight", 64'(inflight), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // single MUL_U 9*10 -> rd 5
    q_rs1 = 5'd5;
    drive(MUL_U, 32'd9, 32'd10, 5'd5);
    #1;
    check("s_ready", 64'(bus.issue_ready), 64'(1));
    check("s_opA", 64'(mul_a), 64'(9));
    check("s_opB", 64'(mul_b), 64'(10));
    check("s_haz_pre", 64'(hazard), 64'(0));
    tick();
    idle();
    #1;
    check("s_idle_opA", 64'(mul_a), 64'(0));
    check("s_inflight", 64'(inflight), 64'(1));
    check("s_wbv0", 64'(bus.wb_valid), 64'(0));
    check("s_haz", 64'(hazard), 64'(1));
    tick();
    check("s_wbv1", 64'(bus.wb_valid), 64'(0));
    tick();
    check_wb("s_wb", 32'd90, 5'd5);
    tick();
    check("s_wbv_off", 64'(bus.wb_valid), 64'(0));
    check("s_inflight0", 64'(inflight), 64'(0));
    check("s_haz_off", 64'(hazard), 64'(0));
    q_rs1 = '0;

    // back-to-back stream
    for (int i = 0; i < 4; i++) begin
      drive(s_op[i], s_a[i], s_b[i], 5'(i + 1));
      tick();
      if (i == 2) check_wb("b0", 32'd45, 5'd1);
      if (i == 3) begin
        check_wb("b1", 32'd2, 5'd2);
        check("b_inflight", 64'(inflight), 64'(3));
      end
    end
    idle();
    tick();
    check_wb("b2", 32'd747409138, 5'd3);
    tick();
    check_wb("b3", 32'hFFFF_FFED, 5'd4);
    tick();
    check("b_end_v", 64'(bus.wb_valid), 64'(0));
    check("b_end_cnt", 64'(inflight), 64'(0));

    // backpressure
    drive(MUL_U, 32'd3, 32'd4, 5'd10);
    tick();
    drive(MUL_U, 32'd5, 32'd6, 5'd11);
    tick();
    idle();
    tick();
    bus.wb_ready = 1'b0;
    #1;
    check("p_ready", 64'(bus.issue_ready), 64'(0));
    check("p_clk_en", 64'(mul_en), 64'(0));
    check_wb("p_hold0", 32'd12, 5'd10);
    tick();
    check_wb("p_hold1", 32'd12, 5'd10);
    check("p_inflight", 64'(inflight), 64'(2));
    tick();
    check_wb("p_hold2", 32'd12, 5'd10);
    bus.wb_ready = 1'b1;
    #1;
    check("p_ready_rel", 64'(bus.issue_ready), 64'(1));
    tick();
    check_wb("p_next", 32'd30, 5'd11);
    tick();
    check("p_end_v", 64'(bus.wb_valid), 64'(0));
    check("p_end_cnt", 64'(inflight), 64'(0));

    // hazard window
    q_rs1 = 5'd7;
    drive(MUL_U, 32'd2, 32'd3, 5'd7);
    #1;
    check("h_same_cyc", 64'(hazard), 64'(0));
    tick();
    idle();
    #1;
    check("h_rs1", 64'(hazard), 64'(1));
    q_rs1 = '0;
    q_rs2 = 5'd7;
    #1;
    check("h_rs2", 64'(hazard), 64'(1));
    tick();
    tick();
    check_wb("h_wb", 32'd6, 5'd7);
    check("h_head", 64'(hazard), 64'(1));
    tick();
    check("h_drop", 64'(hazard), 64'(0));
    q_rs2 = '0;
    drive(MUL_U, 32'd4, 32'd5, 5'd0);
    tick();
    idle();
    #1;
    check("h_x0", 64'(hazard), 64'(0));
    tick();
    tick();
    check_wb("h_x0_wb", 32'd20, 5'd0);
    check("h_x0_head", 64'(hazard), 64'(0));
    tick();

    // flush
    drive(MUL_U, 32'd6, 32'd7, 5'd12);
    tick();
    drive(MUL_U, 32'd8, 32'd9, 5'd13);
    tick();
    check("f_inflight2", 64'(inflight), 64'(2));
    drive(MUL_U, 32'd1, 32'd1, 5'd14);
    flush = 1'b1;
    #1;
    check("f_ready", 64'(bus.issue_ready), 64'(0));
    tick();
    flush = 1'b0;
    idle();
    check("f_inflight0", 64'(inflight), 64'(0));
    check("f_wbv0", 64'(bus.wb_valid), 64'(0));
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("f_wbv%0d", i), 64'(bus.wb_valid), 64'(0));
    end
    check("f_end_cnt", 64'(inflight), 64'(0));

    // reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(MUL_U, 32'(i + 2), 32'd3, 5'(i + 1));
      tick();
    end
    idle();
    check("r_inflight3", 64'(inflight), 64'(3));
    check("r_head", 64'(bus.wb_valid), 64'(1));
    q_rs1 = 5'd2;
    #2;
    rst_n = 1'b0;
    #1;
    check("r_wb_valid", 64'(bus.wb_valid), 64'(0));
    check("r_wb_rd", 64'(bus.wb_rd), 64'(0));
    check("r_wb_data", 64'(bus.wb_data), 64'(0));
    check("r_hazard", 64'(hazard), 64'(0));
    check("r_inflight", 64'(inflight), 64'(0));
    check("r_ready", 64'(bus.issue_ready), 64'(1));
    check("r_clk_en", 64'(mul_en), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    q_rs1 = '0;
    drive(MUL_U, 32'd9, 32'd10, 5'd6);
    tick();
    idle();
    tick();
    tick();
    check_wb("r_fresh", 32'd90, 5'd6);
    tick();
    check("r_end_v", 64'(bus.wb_valid), 64'(0));
    check("r_end_cnt", 64'(inflight), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_issue_unit.md
# mul_issue_unit

Issue and tracking front-end for the fixed-latency pipelined multiplier, `MGT_01_mul_IP`. It accepts M-extension multiply requests from decode over a valid/ready handshake and drives the multiplier's operands, operation and `clk_en_i`. It tracks destination tags through a shift register aligned to the multiplier latency, and presents the result with its `rd` tag to writeback. It also answers RAW hazard queries against in-flight destinations, and supports pipeline flush and writeback backpressure.

## Interface
- `MUL_LATENCY`, default 3: cycles from operand capture to a valid `result_o` in `MGT_01_mul_IP`.
- `TAG_W`, default 5: width of the destination register tag.
- `clk_i` in 1: the single clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `issue_valid_i` in 1: a request is present.
- `issue_ready_o` out 1: the unit accepts the request this cycle.
- `issue_op_i` in `mul_ops_e`: MUL_U, MULH_U, MULHSU_U or MULHU_U.
- `issue_rs1_i` in `data_u`: multiplicand.
- `issue_rs2_i` in `data_u`: multiplier.
- `issue_rd_i` in `TAG_W`: destination tag.
- `flush_i` in 1: kill all in-flight operations.
- `mul_op_A_o` out `data_u`: to the multiplier's `op_A_i`.
- `mul_op_B_o` out `data_u`: to the multiplier's `op_B_i`.
- `mul_ops_o` out `mul_ops_e`: to the multiplier's `ops_i`.
- `mul_clk_en_o` out 1: to the multiplier's `clk_en_i`.
- `mul_result_i` in `data_u`: from the multiplier's `result_o`.
- `wb_valid_o` out 1: a result is available.
- `wb_ready_i` in 1: writeback accepts it.
- `wb_rd_o` out `TAG_W`: tag of the presented result.
- `wb_data_o` out `data_u`: the result.
- `q_rs1_i` in `TAG_W`: first hazard query address.
- `q_rs2_i` in `TAG_W`: second hazard query address.
- `hazard_o` out 1: a queried register has a write in flight.
- `inflight_o` out `$clog2(MUL_LATENCY+1)`: count of valid tracked operations.

## Operation
- **Tracker.** The tracker has `MUL_LATENCY` stages. Each stage holds {valid, rd}. Stage 0 loads on accept; the last stage is the head.
- **Stall.** `stall = wb_valid_o && !wb_ready_i`.
- **Multiplier enable.** `mul_clk_en_o = !stall`. The multiplier and the tracker advance together, so the head always aligns with `mul_result_i`.
- **Issue ready.** `issue_ready_o = !stall && !flush_i`. An accept is `issue_valid_i && issue_ready_o`.
- **Operand drive.** On accept, `mul_op_A_o`, `mul_op_B_o` and `mul_ops_o` pass `issue_*` through combinationally. Otherwise the operands are 0 and the op is MUL_U, to save power. A bubble enters stage 0 with valid=0.
- **Writeback outputs.**
  - `wb_valid_o` = head valid.
  - `wb_rd_o` = head rd.
  - `wb_data_o` = `mul_result_i` while `wb_valid_o`, else 0.
- **Hazard.** `hazard_o` = 1 if any valid stage, including the head, has an rd that is nonzero and equal to `q_rs1_i` or `q_rs2_i`. The path is combinational.
- **rd = 0.** The operation is accepted, tracked and written back. It never raises a hazard.
- **Flush.**
  - Clears every valid bit at the next edge.
  - Takes priority over accept and over stall. A held head is dropped.
  - `inflight_o` becomes 0 on that edge.
- **Occupancy counter.** `inflight_o` is +1 on accept, −1 on a writeback handshake, unchanged when both occur in the same cycle. It never exceeds `MUL_LATENCY`.
- **Reset.**
  - All valid bits, rd fields and `inflight_o` are 0.
  - Therefore `wb_valid_o=0`, `wb_rd_o=0`, `wb_data_o=0` and `hazard_o=0`.
  - `issue_ready_o=1` and `mul_clk_en_o=1`.
  - Asserting reset mid-operation discards all in-flight operations immediately.

## Timing
- **Latency.** An accept at edge k makes `wb_valid_o` high in the cycle after edge k+`MUL_LATENCY`−1, i.e. after `MUL_LATENCY` enabled edges. Each stall cycle adds one cycle.
- **Throughput.** One operation per cycle with no bubbles while `wb_ready_i` is high.
- **During a stall.** Head, data and tag stay stable. The multiplier is frozen through `clk_en`. No new operations are accepted.
- **Same-cycle events.** A writeback handshake and an accept in the same cycle are legal.
- **Hazard window.** `hazard_o` reflects the state as of the current cycle. An operation accepted this cycle is visible to queries from the next cycle.

## Structure
- **Shared package `mgt_01_pkg`.** Existing `data_u` and `mul_ops_e`, plus the new constant `MUL_LATENCY_C` = 3. The top-level `MUL_LATENCY` defaults to it.
- **Sub-module `mul_track_stage`.** One {valid, rd} register with enable, flush and asynchronous active-low reset. Instantiated `MUL_LATENCY` times in a generate loop.

## Test plan
- **Single MUL_U.** rs1=9, rs2=10, rd=5, accepted once, `wb_ready_i`=1 → `wb_valid_o` for exactly one cycle, `MUL_LATENCY` cycles later, with `wb_data_o`=90 and `wb_rd_o`=5.
- **Back-to-back stream.**
  - Ops: MUL_U 45×1 rd=1, then MULH_U 91234×102345 rd=2, then MUL_U 91234×102345 rd=3, then MULHU_U 0xFFFFFFF7×0xFFFFFFF6 rd=4.
  - Required response: four consecutive writebacks of 45, 2, 747409138 and 0xFFFFFFED, in order.
- **Backpressure.** Hold `wb_ready_i`=0 for 2 cycles while the head is valid → `issue_ready_o`=0 and `mul_clk_en_o`=0, head data and tag stable. After release, results resume in order with none lost or duplicated.
- **Hazard query.** With rd=7 in flight, `q_rs1_i`=7 → `hazard_o`=1. `hazard_o` drops in the cycle after its writeback handshake. With rd=0 in flight, `q_rs1_i`=0 → `hazard_o`=0.
- **Flush.**
  - Stimulus: assert `flush_i` with 2 operations in flight and `issue_valid_i` high.
  - During the flush cycle: the new request is not accepted.
  - Next cycle: `inflight_o`=0 and `wb_valid_o`=0, and no writeback occurs for the killed operations.
- **Reset mid-stream.** Assert `rst_n_i` low asynchronously between edges with 3 operations in flight → all outputs take their reset values immediately. After release, a fresh 9×10 operation completes normally.
